// File: rtl/dmem_pkg.sv
// Shared types for the sized data memory: access size, FSM state, byte-count helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_e;

  function automatic logic [3:0] size_bytes(input size_e sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/dmem_load_ext.sv
// Load extension: keeps the low 2^size bytes of the gathered lane and sign/zero extends to 64 bits.
module dmem_load_ext
  import dmem_pkg::*;
(
  input  logic [63:0] raw_i,
  input  size_e       size_i,
  input  logic        unsigned_i,
  output logic [63:0] data_o
);

  always_comb begin
    data_o = raw_i;
    case (size_i)
      SZ_B: data_o = unsigned_i ? {56'd0, raw_i[7:0]}  : {{56{raw_i[7]}},  raw_i[7:0]};
      SZ_H: data_o = unsigned_i ? {48'd0, raw_i[15:0]} : {{48{raw_i[15]}}, raw_i[15:0]};
      SZ_W: data_o = unsigned_i ? {32'd0, raw_i[31:0]} : {{32{raw_i[31]}}, raw_i[31:0]};
      SZ_D: data_o = raw_i;
      default: data_o = raw_i;
    endcase
  end

endmodule

// File: rtl/dmem_sized.sv
// Sized byte-addressed data memory with 1-cycle registered response and post-reset clear sweep.
// Optional misalignment trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_sized
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int DEPTH_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int IDX_W  = $clog2(DEPTH_BYTES);
  localparam int NUM_DW = DEPTH_BYTES / 8;
  localparam int PTR_W  = (NUM_DW > 1) ? $clog2(NUM_DW) : 1;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [7:0]       mem_q [DEPTH_BYTES];

  logic             rsp_valid_q, rsp_valid_d;
  logic [63:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;

  size_e            size;
  logic [3:0]       nbytes;
  logic [ADDR_W:0]  last_addr;
  logic             range_err, acc_err, accept, do_store, clear_we;
  logic [IDX_W-1:0] lane_idx [8];
  logic [IDX_W-1:0] clr_idx [8];
  logic [7:0]       lane_en;
  logic [63:0]      raw_lane, ext_data;

  // Handshake: a request transfers on any edge where req_valid & req_ready; there is no
  // response backpressure, so rsp_* is a single-cycle pulse the consumer must take.
  assign accept = req_valid & req_ready;

  assign size      = size_e'(req_size);
  assign nbytes    = size_bytes(size);
  // One extra bit so an access running past the top of the address space cannot wrap.
  assign last_addr = {1'b0, req_addr} + (ADDR_W+1)'(nbytes - 4'd1);
  assign range_err = last_addr >= (ADDR_W+1)'(DEPTH_BYTES);

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misalign;
  assign misalign = |(req_addr[2:0] & 3'(nbytes - 4'd1));
  assign acc_err  = range_err | misalign;
`else
  assign acc_err  = range_err;
`endif

  assign do_store = accept & req_we & ~acc_err;

  always_comb begin
    raw_lane = '0;
    lane_en  = '0;
    for (int k = 0; k < 8; k++) begin
      lane_idx[k]      = req_addr[IDX_W-1:0] + IDX_W'(k);
      clr_idx[k]       = (IDX_W'(ptr_q) << 3) | IDX_W'(k);
      lane_en[k]       = 4'(k) < nbytes;
      raw_lane[8*k +: 8] = mem_q[lane_idx[k]];
    end
  end

  dmem_load_ext u_load_ext (
    .raw_i      (raw_lane),
    .size_i     (size),
    .unsigned_i (req_unsigned),
    .data_o     (ext_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (state_q == CLEAR) begin
      ptr_d = ptr_q + 1'b1;
      if (ptr_q == PTR_W'(NUM_DW - 1)) state_d = RUN;
    end
  end

  always_comb begin
    req_ready = (state_q == RUN);
    busy      = (state_q == CLEAR);
    clear_we  = (state_q == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      if (clear_we) begin
        for (int k = 0; k < 8; k++) mem_q[clr_idx[k]] <= 8'h00;
      end else if (do_store) begin
        for (int k = 0; k < 8; k++) begin
          if (lane_en[k]) mem_q[lane_idx[k]] <= req_wdata[8*k +: 8];
        end
      end
    end
  end

  always_comb begin
    rsp_valid_d = accept;
    rsp_err_d   = accept & acc_err;
    rsp_rdata_d = (accept && !req_we && !acc_err) ? ext_data : 64'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: reset/sweep timing, table of loads/stores, back-to-back and reset corners.
module tb_dmem_sized;

  localparam int ADDR_W = 64;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [63:0]       req_wdata = '0;
  logic              rsp_valid;
  logic [63:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;

  always #5 clk = ~clk;

  dmem_sized #(.ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .busy         (busy)
  );

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t        vecs[$];
  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input logic we, input logic [1:0] size, input logic uns,
                     input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [63:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Drives one request for a single edge, then checks the response pulse #1 after that edge.
  task automatic issue(input vec_t v);
    logic [63:0] exp;
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    exp_q.push_back(v.exp_rdata);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp = exp_q.pop_front();
    chk({v.name, " rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({v.name, " rsp_rdata"}, rsp_rdata, exp);
    chk({v.name, " rsp_err"},   64'(rsp_err),   64'(v.exp_err));
  endtask

  // Holds a load request through the sweep; counts CLEAR cycles and any spurious response.
  task automatic count_clear(input string name);
    int n = 0;
    int spurious = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = '0;
    chk({name, " busy at start"}, 64'(busy), 64'd1);
    chk({name, " ready at start"}, 64'(req_ready), 64'd0);
    while (busy && n < 200) begin
      @(posedge clk); #1;
      n++;
      if (rsp_valid) spurious++;
    end
    req_valid = 1'b0;
    chk({name, " clear cycles"}, 64'(n), 64'd32);
    chk({name, " rsp during clear"}, 64'(spurious), 64'd0);
    chk({name, " ready after clear"}, 64'(req_ready), 64'd1);
  endtask

  vec_t v;
  logic [63:0] mis_rdata_w, mis_rdata_d;
  logic        mis_err;

  initial begin
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_err = 1'b1; mis_rdata_w = 64'd0; mis_rdata_d = 64'd0;
`else
    mis_err = 1'b0; mis_rdata_w = 64'h0000_0000_CAFE_F00D; mis_rdata_d = 64'h0000_CAFE_F00D_0000;
`endif

    add("ld_d_0x00",      0, 2'd3, 0, 64'h00, 64'h0, 64'h0, 0);
    add("ld_d_0xf8",      0, 2'd3, 0, 64'hF8, 64'h0, 64'h0, 0);
    add("st_d_0x10",      1, 2'd3, 0, 64'h10, 64'h1122334455667788, 64'h0, 0);
    add("ld_b_s_0x17",    0, 2'd0, 0, 64'h17, 64'h0, 64'h11, 0);
    add("ld_h_u_0x10",    0, 2'd1, 1, 64'h10, 64'h0, 64'h7788, 0);
    add("ld_w_s_0x14",    0, 2'd2, 0, 64'h14, 64'h0, 64'h11223344, 0);
    add("ld_h_s_0x12",    0, 2'd1, 0, 64'h12, 64'h0, 64'h5566, 0);
    add("ld_b_s_0x10",    0, 2'd0, 0, 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 0);
    add("ld_d_u_0x10",    0, 2'd3, 1, 64'h10, 64'h0, 64'h1122334455667788, 0);
    add("st_b_0x20",      1, 2'd0, 0, 64'h20, 64'hAAAA_AAAA_AAAA_AA80, 64'h0, 0);
    add("ld_b_s_0x20",    0, 2'd0, 0, 64'h20, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0);
    add("ld_b_u_0x20",    0, 2'd0, 1, 64'h20, 64'h0, 64'h80, 0);
    add("ld_d_0x20",      0, 2'd3, 0, 64'h20, 64'h0, 64'h80, 0);
    add("ld_d_0xf9_err",  0, 2'd3, 0, 64'hF9, 64'h0, 64'h0, 1);
    add("st_w_0x100_err", 1, 2'd2, 0, 64'h100, 64'hFFFF_FFFF, 64'h0, 1);
    add("ld_d_0x00_kept", 0, 2'd3, 0, 64'h00, 64'h0, 64'h0, 0);
    add("ld_b_huge_err",  0, 2'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 1);
    add("st_w_0xfc",      1, 2'd2, 0, 64'hFC, 64'h1234_5678_DEAD_BEEF, 64'h0, 0);
    add("ld_w_u_0xfc",    0, 2'd2, 1, 64'hFC, 64'h0, 64'hDEAD_BEEF, 0);
    add("ld_w_s_0xfc",    0, 2'd2, 0, 64'hFC, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, 0);
    add("ld_h_s_0xfe",    0, 2'd1, 0, 64'hFE, 64'h0, 64'hFFFF_FFFF_FFFF_DEAD, 0);
    add("ld_b_u_0xff",    0, 2'd0, 1, 64'hFF, 64'h0, 64'hDE, 0);
    add("ld_h_0xff_err",  0, 2'd1, 1, 64'hFF, 64'h0, 64'h0, 1);
    add("st_w_0x02_mis",  1, 2'd2, 0, 64'h02, 64'h9999_8888_CAFE_F00D, 64'h0, mis_err);
    add("ld_w_u_0x02",    0, 2'd2, 1, 64'h02, 64'h0, mis_rdata_w, mis_err);
    add("ld_d_0x00_mis",  0, 2'd3, 0, 64'h00, 64'h0, mis_rdata_d, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset busy",      64'(busy),      64'd1);
    chk("reset rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset rsp_rdata", rsp_rdata,      64'd0);
    chk("reset rsp_err",   64'(rsp_err),   64'd0);

    rst = 1'b1;
    count_clear("sweep");

    for (int i = 0; i < vecs.size(); i++) issue(vecs[i]);

    @(posedge clk); #1;
    chk("idle rsp_valid", 64'(rsp_valid), 64'd0);

    v.name = "b2b_st_d_0x40"; v.we = 1; v.size = 2'd3; v.uns = 0; v.addr = 64'h40;
    v.wdata = 64'h0123_4567_89AB_CDEF; v.exp_rdata = 64'h0; v.exp_err = 0;
    issue(v);
    v.name = "b2b_ld_d_0x40"; v.we = 0; v.exp_rdata = 64'h0123_4567_89AB_CDEF;
    issue(v);

    // Reset asserted on the same edge as a valid load: no response may appear.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd3; req_addr = 64'h40;
    rst = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst drop rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst drop rsp_rdata", rsp_rdata,      64'd0);
    chk("rst busy",           64'(busy),      64'd1);

    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid-clear busy", 64'(busy), 64'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    count_clear("restart");

    v.name = "post_clear_ld_0x40"; v.we = 0; v.size = 2'd3; v.uns = 0; v.addr = 64'h40;
    v.wdata = 64'h0; v.exp_rdata = 64'h0; v.exp_err = 0;
    issue(v);
    v.name = "post_clear_ld_0x10"; v.addr = 64'h10;
    issue(v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
